fwd_hazard_unit: RTL and testbench

- Tracks in-flight destination registers across the EX, MEM and WB pipeline stages of the vector processor.
- Generates registered 2-bit forwarding selects that drive the EX-stage operand muxes:
  - 00 = register file
  - 01 = WB result
  - 10 = MEM result
  - 11 = zero (never issued)
- Raises `stall` for load-use hazards and for multi-cycle vector operations occupying EX.

---
 rtl/fwd_hazard_unit.sv | 122 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: tracks EX/MEM/WB destination records, issues
// registered EX operand-mux selects and stalls for load-use and vector ops.
module fwd_hazard_unit #(
  parameter int REG_BITS   = 4,
  parameter int VEC_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_we,
  input  logic                id_is_load,
  input  logic                id_is_vec,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                ex_busy
);

  localparam int CW = (VEC_CYCLES > 1) ? $clog2(VEC_CYCLES) + 1 : 1;
  localparam logic [CW-1:0] CNT_INIT  = CW'(VEC_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                we;
    logic                is_load;
    logic                is_vec;
  } rec_t;

  typedef enum logic {IDLE, BUSY} vstate_e;

  rec_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_rec;
  vstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic          ex_busy_q, ex_busy_d;
  logic          m_ex_a, m_ex_b, m_mem_a, m_mem_b, load_use, take;

  function automatic logic hit(rec_t r, logic [REG_BITS-1:0] rs, logic used);
    return r.valid & r.we & (r.rd == rs) & (rs != '0) & used;
  endfunction

  // Youngest producer wins: EX result arrives from MEM next cycle.
  function automatic logic [1:0] pick(logic m_ex, logic m_mem);
    return m_ex ? 2'b10 : (m_mem ? 2'b01 : 2'b00);
  endfunction

  always_comb begin
    id_rec   = '{valid: id_valid, rd: id_rd, we: id_we,
                 is_load: id_is_load, is_vec: id_is_vec};
    m_ex_a   = hit(ex_q,  id_rs1, id_rs1_used);
    m_ex_b   = hit(ex_q,  id_rs2, id_rs2_used);
    m_mem_a  = hit(mem_q, id_rs1, id_rs1_used);
    m_mem_b  = hit(mem_q, id_rs2, id_rs2_used);
    load_use = ex_q.is_load & (m_ex_a | m_ex_b);
    stall    = id_valid & ~flush & (load_use | ex_busy_q);
    take     = id_valid & ~stall & ~flush;

    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;

    if (state_q == BUSY) begin
      // Stages below EX drain one slot on the first busy cycle, then freeze.
      if (cnt_q == CNT_INIT) begin
        wb_d  = mem_q;
        mem_d = '0;
      end
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) state_d = IDLE;
    end else begin
      wb_d    = mem_q;
      mem_d   = ex_q;
      ex_d    = take ? id_rec : '0;
      fwd_a_d = take ? pick(m_ex_a, m_mem_a) : 2'b00;
      fwd_b_d = take ? pick(m_ex_b, m_mem_b) : 2'b00;
      if (take && id_is_vec && (VEC_CYCLES > 1)) begin
        cnt_d   = CNT_INIT;
        state_d = BUSY;
      end
    end
    ex_busy_d = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
      ex_busy_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      ex_busy_q <= ex_busy_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign ex_busy   = ex_busy_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plan followed by random traffic, checked against a cycle-level
// pipeline model built from the forwarding/stall rules.
module tb_fwd_hazard_unit;
  localparam int RB  = 4;
  localparam int VEC = 4;

  logic          clk = 1'b0;
  logic          rst_n, id_valid, id_rs1_used, id_rs2_used, id_we;
  logic          id_is_load, id_is_vec, flush;
  logic [RB-1:0] id_rs1, id_rs2, id_rd;
  logic          stall, ex_busy;
  logic [1:0]    fwd_a_sel, fwd_b_sel;

  int errors = 0;
  int checks = 0;

  fwd_hazard_unit #(.REG_BITS(RB), .VEC_CYCLES(VEC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .id_is_vec(id_is_vec), .flush(flush), .stall(stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  // Model: one entry per stage, plus cycles the EX vector op still holds EX.
  typedef struct {
    bit v; int rd; bit we; bit ld; bit vec;
  } rec_t;

  rec_t m_ex, m_mem, m_wb;
  int   m_left;
  bit   m_first;
  int   m_fa, m_fb;
  bit   obs_stall;
  int   busy_cnt, stall_cnt;

  function automatic rec_t empty_rec();
    rec_t r;
    r.v = 0; r.rd = 0; r.we = 0; r.ld = 0; r.vec = 0;
    return r;
  endfunction

  function automatic bit hit(rec_t r, int rs, bit used);
    return r.v && r.we && (r.rd == rs) && (rs != 0) && used;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ex = empty_rec(); m_mem = empty_rec(); m_wb = empty_rec();
    m_left = 0; m_first = 0; m_fa = 0; m_fb = 0;
  endtask

  // One clock: drive ID, check stall mid-cycle, clock, check registered outputs.
  task automatic step(input bit v, input int rs1, input bit u1, input int rs2,
                      input bit u2, input int rd, input bit we, input bit ld,
                      input bit vec, input bit fl, input bit rst);
    bit   exp_stall, enter;
    rec_t nr;
    rst_n = ~rst; id_valid = v; id_rs1 = RB'(rs1); id_rs2 = RB'(rs2);
    id_rs1_used = u1; id_rs2_used = u2; id_rd = RB'(rd); id_we = we;
    id_is_load = ld; id_is_vec = vec; flush = fl;
    #2;
    exp_stall = v && !fl && ((m_left > 0) ||
                (m_ex.ld && (hit(m_ex, rs1, u1) || hit(m_ex, rs2, u2))));
    obs_stall = stall;
    if (!rst) chk("stall", {1'b0, stall}, {1'b0, exp_stall});
    @(posedge clk);
    if (rst) model_reset();
    else if (m_left > 0) begin
      if (m_first) begin m_wb = m_mem; m_mem = empty_rec(); end
      m_first = 0;
      m_left--;
    end else begin
      enter = v && !exp_stall && !fl;
      m_fa = !enter ? 0 : hit(m_ex, rs1, u1) ? 2 : hit(m_mem, rs1, u1) ? 1 : 0;
      m_fb = !enter ? 0 : hit(m_ex, rs2, u2) ? 2 : hit(m_mem, rs2, u2) ? 1 : 0;
      nr.v = 1; nr.rd = rd; nr.we = we; nr.ld = ld; nr.vec = vec;
      m_wb = m_mem; m_mem = m_ex; m_ex = enter ? nr : empty_rec();
      if (enter && vec && VEC > 1) begin m_left = VEC - 1; m_first = 1; end
    end
    #1;
    chk("fwd_a", fwd_a_sel, 2'(m_fa));
    chk("fwd_b", fwd_b_sel, 2'(m_fb));
    chk("ex_busy", {1'b0, ex_busy}, {1'b0, m_left > 0});
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input int rs1, input int rs2, input int rd);
    step(1, rs1, 1, rs2, 1, rd, 1, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_fwd_a", fwd_a_sel, 2'b00);
    chk("rst_fwd_b", fwd_b_sel, 2'b00);
    chk("rst_busy", {1'b0, ex_busy}, 2'b00);
    nop();

    // 1: back-to-back dependency
    alu(1, 2, 3);
    alu(3, 4, 6);
    chk("t1_stall", {1'b0, obs_stall}, 2'b00);
    chk("t1_fwd_a", fwd_a_sel, 2'b10);
    chk("t1_fwd_b", fwd_b_sel, 2'b00);
    nop(); nop();

    // 2: distance-2, then two writers
    alu(1, 2, 5);
    alu(7, 8, 6);
    alu(9, 5, 10);
    chk("t2_fwd_b_mem", fwd_b_sel, 2'b01);
    alu(1, 2, 5);
    alu(8, 1, 5);
    alu(9, 5, 10);
    chk("t2_fwd_b_ex", fwd_b_sel, 2'b10);
    nop(); nop();

    // 3: load-use
    step(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0);
    alu(2, 7, 8);
    chk("t3_stall", {1'b0, obs_stall}, 2'b01);
    chk("t3_bubble_a", fwd_a_sel, 2'b00);
    alu(2, 7, 8);
    chk("t3_stall_clr", {1'b0, obs_stall}, 2'b00);
    chk("t3_fwd_a", fwd_a_sel, 2'b01);
    nop(); nop();

    // 4: vector occupancy
    step(1, 1, 1, 2, 1, 9, 1, 0, 1, 0, 0);
    busy_cnt = ex_busy ? 1 : 0;
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      alu(12, 13, 14);
      if (obs_stall) stall_cnt++;
      if (ex_busy) busy_cnt++;
      if (!obs_stall) break;
    end
    chk("t4_stalls", 2'(stall_cnt), 2'd3);
    chk("t4_busy", 2'(busy_cnt), 2'd3);
    nop(); nop();

    // 5A: r0 never forwards
    alu(1, 2, 0);
    alu(0, 0, 4);
    chk("t5_r0_a", fwd_a_sel, 2'b00);
    chk("t5_r0_b", fwd_b_sel, 2'b00);
    // 5B: flush beats load-use
    step(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0);
    step(1, 2, 1, 0, 0, 8, 1, 0, 0, 1, 0);
    chk("t5_flush_stall", {1'b0, obs_stall}, 2'b00);
    chk("t5_flush_a", fwd_a_sel, 2'b00);
    nop(); nop();

    // 6: reset mid-vector
    step(1, 1, 1, 2, 1, 11, 1, 0, 1, 0, 0);
    nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t6_busy", {1'b0, ex_busy}, 2'b00);
    chk("t6_fwd_a", fwd_a_sel, 2'b00);
    alu(11, 11, 3);
    chk("t6_stall", {1'b0, obs_stall}, 2'b00);
    chk("t6_rd_a", fwd_a_sel, 2'b00);
    chk("t6_rd_b", fwd_b_sel, 2'b00);

    // Random traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
